// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state
// encoding and the default operand width.
package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // Encoding 2'd3 is never entered; the controller treats it as IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/half_add.sv
// Combinational half adder cell, the basic datapath element that the
// serial adder chains into a full-adder step.
module half_add (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b;
  assign carry = a & b;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial word adder: operands are accepted over a valid/ready
// handshake, summed one bit per clock (LSB first) through a shared pair
// of half adders, and returned with the carry-out over a second handshake.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t state_q;
  state_t state_d;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;

  logic s1;
  logic c1;
  logic s;
  logic c2;

  // Two half adders form the full adder that handles the current bit.
  half_add u_ha_operands (
    .a     (a_sh[0]),
    .b     (b_sh[0]),
    .sum   (s1),
    .carry (c1)
  );

  half_add u_ha_carry (
    .a     (s1),
    .b     (carry_q),
    .sum   (s),
    .carry (c2)
  );

  // Next-state decode; the unused encoding falls back to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_valid)          state_d = RUN;
      RUN:  if (cnt_q == LAST_BIT) state_d = DONE;
      DONE: if (out_ready)         state_d = IDLE;
      default:                     state_d = IDLE;
    endcase
  end

  // State register plus the operand/sum shifters, carry and bit counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh    <= '0;
      b_sh    <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_sh    <= a;
            b_sh    <= b;
            carry_q <= cin;
            sum_q   <= '0;
            cnt_q   <= '0;
          end
        end
        RUN: begin
          carry_q <= c1 | c2;
          sum_q   <= {s, sum_q[WIDTH-1:1]};
          a_sh    <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh    <= {1'b0, b_sh[WIDTH-1:1]};
          cnt_q   <= cnt_q + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = carry_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8): a scoreboard queue is
// filled with a+b+cin on every input handshake and drained on every output
// handshake, with directed corner cases, backpressure, reset and random load.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;

  int nChecks = 0;
  int nFails  = 0;
  int cycle   = 0;
  int lastAcc = -1;
  bit gapCheck = 1'b0;

  logic [W:0] expQ[$];
  logic [W:0] expVal;
  logic [W:0] bpExp;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  // Free-running clock and cycle counter.
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Single comparison point for every check in the bench.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: push on input handshake, pop and compare on output handshake.
  always @(negedge clk) begin
    if (!rst && in_valid && in_ready) begin
      expQ.push_back({1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin});
      if (gapCheck && lastAcc >= 0) checkOutput("accGap", cycle - lastAcc, 10);
      lastAcc = cycle;
    end
    if (!rst && out_valid && out_ready) begin
      if (expQ.size() == 0) begin
        checkOutput("sbEmpty", 1, 0);
      end else begin
        expVal = expQ.pop_front();
        checkOutput("result", {cout, sum}, expVal);
      end
    end
  end

  // Present operands and hold in_valid until the DUT takes them.
  task automatic applyStimulus(input logic [W-1:0] ta, input logic [W-1:0] tb,
                               input logic tc, output bit ok);
    a = ta;
    b = tb;
    cin = tc;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
    end
    if (!ok) checkOutput("acceptTimeout", 0, 1);
    else begin
      @(posedge clk);
      #1;
    end
  endtask

  // Wait for out_valid, check latency, then consume with a one-cycle pulse.
  task automatic collectResult();
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (out_valid) seen = 1'b1;
    end
    if (!seen) checkOutput("resultTimeout", 0, 1);
    else begin
      checkOutput("latency", n - 1, W);
      @(posedge clk);
      #1 out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
    end
  endtask

  task automatic doOp(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc);
    bit ok;
    applyStimulus(ta, tb, tc, ok);
    in_valid = 1'b0;
    if (ok) collectResult();
  endtask

  // Main sequence of directed and random scenarios.
  initial begin
    bit ok;
    bit seen;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rstInReady", in_ready, 1);
    checkOutput("rstOutValid", out_valid, 0);
    checkOutput("rstSum", sum, 0);
    checkOutput("rstCout", cout, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    $display("[TB] directed corner cases");
    doOp(8'h00, 8'h00, 1'b0);
    doOp(8'hFF, 8'h01, 1'b0);
    doOp(8'hA5, 8'h5A, 1'b1);

    $display("[TB] backpressure");
    applyStimulus(8'h37, 8'h4C, 1'b1, ok);
    bpExp = 9'h084;
    in_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    if (!seen) checkOutput("bpTimeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    a = 8'h11;
    b = 8'h22;
    cin = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bpOutValid", out_valid, 1);
      checkOutput("bpInReady", in_ready, 0);
      checkOutput("bpHold", {cout, sum}, bpExp);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("bpInReadyAfter", in_ready, 1);
    checkOutput("bpNotTaken", expQ.size(), 0);
    repeat (10) @(negedge clk);
    checkOutput("bpNoRun", out_valid, 0);

    $display("[TB] reset mid-operation");
    @(posedge clk);
    #1;
    applyStimulus(8'hFF, 8'hFF, 1'b1, ok);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    expQ.delete();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midRstOutValid", out_valid, 0);
    checkOutput("midRstInReady", in_ready, 1);
    checkOutput("midRstSum", sum, 0);
    checkOutput("midRstCout", cout, 0);
    @(posedge clk);
    #1;
    doOp(8'h3C, 8'hC3, 1'b0);

    $display("[TB] back-to-back random");
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    lastAcc = -1;
    gapCheck = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      applyStimulus(W'($urandom), W'($urandom), 1'($urandom), ok);
      if (!ok) break;
    end
    in_valid = 1'b0;
    for (int i = 0; i < 40 && expQ.size() != 0; i++) @(posedge clk);
    #1;
    checkOutput("drain", expQ.size(), 0);
    gapCheck = 1'b0;
    out_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
